// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - instruction formats, opcodes and immediate limits shared by the encoder
package enc_pkg;

    typedef enum logic [2:0] {
        FMT_I_LOAD  = 3'd0,
        FMT_I_ALU   = 3'd1,
        FMT_SHIFT   = 3'd2,
        FMT_S       = 3'd3,
        FMT_B       = 3'd4,
        FMT_JALR    = 3'd5,
        FMT_MEMCOPY = 3'd6,
        FMT_ILLEGAL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I_ALU   = 7'b0010011;
    localparam logic [6:0] OP_SHIFT   = 7'b0010011;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_MEMCOPY = 7'b1111111;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int SHAMT_MIN = 0;
    localparam int SHAMT_MAX = 31;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;

    function automatic logic [6:0] opcode_of(input fmt_e f);
        case (f)
            FMT_I_LOAD:  return OP_I_LOAD;
            FMT_I_ALU:   return OP_I_ALU;
            FMT_SHIFT:   return OP_SHIFT;
            FMT_S:       return OP_S;
            FMT_B:       return OP_B;
            FMT_JALR:    return OP_JALR;
            FMT_MEMCOPY: return OP_MEMCOPY;
            default:     return 7'b0000000;
        endcase
    endfunction

    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - field-bundle input and encoded-word output handshakes
interface inst_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_code;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    modport slave (
        input  in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, inst_code, out_addr, out_err, err_count
    );

    modport master (
        output in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, inst_code, out_addr, out_err, err_count
    );
endinterface

// File: rtl/enc_fifo.sv
// rtl/enc_fifo.sv - output word buffer; reads as zero while empty
module enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - packs instruction fields into 32-bit words with range flagging and addressing
module inst_encoder
    import enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 2
) (
    input logic           clk,
    input logic           rst_n,
    inst_encoder_if.slave bus
);
    fmt_e        fmt_q;
    int          simm;
    logic        ok;
    logic [12:0] immv;
    logic [6:0]  op;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        wr_en;
    logic        rd_en;
    logic        full;
    logic        empty;
    logic [32:0] rdata;
    logic [31:0] addr_q;
    logic [7:0]  err_q;

    always_comb begin
        fmt_q    = fmt_e'(bus.fmt);
        simm     = $signed(bus.imm);
        op       = opcode_of(fmt_q);
        ok       = 1'b0;
        enc_word = '0;
        case (fmt_q)
            FMT_I_LOAD, FMT_I_ALU, FMT_JALR, FMT_S, FMT_MEMCOPY:
                ok = in_range(simm, IMM12_MIN, IMM12_MAX);
            FMT_SHIFT: ok = in_range(simm, SHAMT_MIN, SHAMT_MAX);
            FMT_B:     ok = in_range(simm, IMMB_MIN, IMMB_MAX) && !bus.imm[0];
            default:   ok = 1'b0;
        endcase
        // Out-of-range words keep their register fields; only the immediate is dropped.
        immv = ok ? bus.imm[12:0] : 13'd0;
        case (fmt_q)
            FMT_I_LOAD, FMT_I_ALU, FMT_JALR:
                enc_word = {immv[11:0], bus.rs1, bus.funct3, bus.rd, op};
            FMT_SHIFT:
                enc_word = {bus.funct7, immv[4:0], bus.rs1, bus.funct3, bus.rd, op};
            FMT_S, FMT_MEMCOPY:
                enc_word = {immv[11:5], bus.rs2, bus.rs1, bus.funct3, immv[4:0], op};
            FMT_B:
                enc_word = {immv[12], immv[10:5], bus.rs2, bus.rs1, bus.funct3,
                            immv[4:1], immv[11], op};
            default:
                enc_word = '0;
        endcase
        enc_err = !ok;
    end

    assign wr_en = bus.in_valid && !full;
    assign rd_en = bus.out_ready && !empty;

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .wdata ({enc_err, enc_word}),
        .full  (full),
        .rd_en (rd_en),
        .rdata (rdata),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BASE_ADDR;
            err_q  <= '0;
        end else begin
            if (rd_en)
                addr_q <= addr_q + 32'd4;
            if (wr_en && enc_err && (err_q != 8'hFF))
                err_q <= err_q + 8'd1;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.inst_code = rdata[31:0];
    assign bus.out_err   = rdata[32];
    assign bus.out_addr  = addr_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed vector bench for inst_encoder
module tb_inst_encoder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic [2:0]  fmt;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] code;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic [31:0] exp_addr;
    int   exp_cnt;
    vec_t vecs[16];

    inst_encoder_if bus();

    inst_encoder #(
        .BASE_ADDR (BASE),
        .DEPTH     (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.fmt    = v.fmt;
        bus.funct3 = v.f3;
        bus.funct7 = v.f7;
        bus.rd     = v.rd;
        bus.rs1    = v.rs1;
        bus.rs2    = v.rs2;
        bus.imm    = v.imm;
    endtask

    task automatic alu_word(input logic [31:0] imm);
        vec_t v;
        v = '{3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, imm, 32'h0, 1'b0};
        drive(v);
    endtask

    initial begin
        vecs[0]  = '{3'd1, 3'b000, 7'd0,       5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF, 32'hFFF30293, 1'b0};
        vecs[1]  = '{3'd4, 3'b000, 7'd0,       5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE208EE3, 1'b0};
        vecs[2]  = '{3'd4, 3'b000, 7'd0,       5'd0, 5'd1, 5'd2, 32'd3,         32'h00208063, 1'b1};
        vecs[3]  = '{3'd2, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3,         32'h4030D093, 1'b0};
        vecs[4]  = '{3'd2, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd32,        32'h4000D093, 1'b1};
        vecs[5]  = '{3'd0, 3'b010, 7'd0,       5'd2, 5'd3, 5'd0, 32'd2047,      32'h7FF1A103, 1'b0};
        vecs[6]  = '{3'd0, 3'b010, 7'd0,       5'd2, 5'd3, 5'd0, 32'd2048,      32'h0001A103, 1'b1};
        vecs[7]  = '{3'd0, 3'b010, 7'd0,       5'd2, 5'd3, 5'd0, 32'hFFFF_F800, 32'h8001A103, 1'b0};
        vecs[8]  = '{3'd3, 3'b010, 7'd0,       5'd0, 5'd2, 5'd3, 32'd8,         32'h00312423, 1'b0};
        vecs[9]  = '{3'd5, 3'b000, 7'd0,       5'd1, 5'd5, 5'd0, 32'd4,         32'h004280E7, 1'b0};
        vecs[10] = '{3'd6, 3'b000, 7'd0,       5'd0, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFE208FFF, 1'b0};
        vecs[11] = '{3'd7, 3'b111, 7'h7F,      5'd9, 5'd9, 5'd9, 32'd5,         32'h00000000, 1'b1};
        vecs[12] = '{3'd4, 3'b000, 7'd0,       5'd0, 5'd0, 5'd0, 32'd4094,      32'h7E000FE3, 1'b0};
        vecs[13] = '{3'd4, 3'b000, 7'd0,       5'd0, 5'd0, 5'd0, 32'd4096,      32'h00000063, 1'b1};
        vecs[14] = '{3'd4, 3'b000, 7'd0,       5'd0, 5'd0, 5'd0, 32'hFFFF_F000, 32'h80000063, 1'b0};
        vecs[15] = '{3'd2, 3'b001, 7'd0,       5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h00001013, 1'b1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_out_addr",  bus.out_addr,           BASE);
        chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);
        chk("rst_inst_code", bus.inst_code,          32'd0);
        chk("rst_out_err",   {31'd0, bus.out_err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = BASE;
        exp_cnt  = 0;

        // Table: one word at a time through an empty FIFO with the consumer ready.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (vecs[i].err) exp_cnt++;
            chk($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d_code", i),  bus.inst_code,          vecs[i].code);
            chk($sformatf("v%0d_err", i),   {31'd0, bus.out_err},   {31'd0, vecs[i].err});
            chk($sformatf("v%0d_addr", i),  bus.out_addr,           exp_addr);
            chk($sformatf("v%0d_cnt", i),   {24'd0, bus.err_count}, exp_cnt);
            @(posedge clk);
            #1;
            exp_addr = exp_addr + 32'd4;
            chk($sformatf("v%0d_drain", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Backpressure: three pushes into a two-entry FIFO, then drain in order.
        @(negedge clk);
        bus.out_ready = 1'b0;
        alu_word(32'd1);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_after1", {31'd0, bus.in_ready}, 32'd1);
        alu_word(32'd2);
        @(posedge clk);
        #1;
        chk("bp_ready_after2", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_head_code",    bus.inst_code,         32'h00100093);
        alu_word(32'd3);
        @(posedge clk);
        #1;
        chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold_code",  bus.inst_code,         32'h00100093);
        chk("bp_hold_addr",  bus.out_addr,          exp_addr);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_w2_code", bus.inst_code, 32'h00200093);
        chk("bp_w2_addr", bus.out_addr,  exp_addr + 32'd4);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_w3_code", bus.inst_code, 32'h00300093);
        chk("bp_w3_addr", bus.out_addr,  exp_addr + 32'd8);
        @(posedge clk);
        #1;
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Illegal-format stream saturates the error counter.
        @(negedge clk);
        drive(vecs[11]);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (i == 99) begin
                #1;
                chk("sat_cnt_mid", {24'd0, bus.err_count}, exp_cnt + 100);
            end
        end
        #1;
        chk("sat_cnt",  {24'd0, bus.err_count}, 32'd255);
        chk("sat_code", bus.inst_code,          32'd0);
        chk("sat_err",  {31'd0, bus.out_err},   32'd1);
        chk("sat_busy", {31'd0, bus.out_valid}, 32'd1);

        // Reset mid-stream takes effect without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mrst_out_addr",  bus.out_addr,           BASE);
        chk("mrst_err_count", {24'd0, bus.err_count}, 32'd0);
        chk("mrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("mrst_code",      bus.inst_code,          32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_discard", {31'd0, bus.out_valid}, 32'd0);

        @(negedge clk);
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("post_code", bus.inst_code, 32'hFFF30293);
        chk("post_addr", bus.out_addr,  BASE);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
